// File: rtl/nibble_serial_add_ctrl.sv
// Serial wide adder: one 4-bit ripple slice reused over NIBBLES cycles, LSB nibble first.
// Optional macro SERIAL_SUB_EN adds a 'sub' port for A-B via inverted B and carry-in of 1.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module nibble_serial_add_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
`ifdef SERIAL_SUB_EN
    input  logic                   sub,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES:0]     sum
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            sub_q, sub_d;
    logic            carry_q, carry_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W:0]      sum_q, sum_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            sub_in_c;
    logic [3:0]      slice_a_c;
    logic [3:0]      slice_b_c;
    logic [3:0]      slice_s_c;
    logic [4:0]      slice_cy_c;

`ifdef SERIAL_SUB_EN
    assign sub_in_c = sub;
`else
    assign sub_in_c = 1'b0;
`endif

    // Current nibble of each operand; B is inverted for subtraction.
    assign slice_a_c     = a_q[4*idx_q +: 4];
    assign slice_b_c     = b_q[4*idx_q +: 4] ^ {4{sub_q}};
    assign slice_cy_c[0] = carry_q;

    // 4-bit ripple slice; carry-in comes from the inter-nibble carry register.
    for (genvar i = 0; i < 4; i++) begin : g_slice
        full_adder u_fa (
            .a    (slice_a_c[i]),
            .b    (slice_b_c[i]),
            .cin  (slice_cy_c[i]),
            .s    (slice_s_c[i]),
            .cout (slice_cy_c[i+1])
        );
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub_in_c;
                    sum_d   = '0;
                    carry_d = sub_in_c;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d[4*idx_q +: 4] = slice_s_c;
                carry_d             = slice_cy_c[4];
                idx_d               = idx_q + IW'(1);
                if (idx_q == IW'(NIBBLES - 1)) begin
                    sum_d[W] = slice_cy_c[4];
                    idx_d    = '0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ADD);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencer that computes wide (4*NIBBLES-bit) unsigned sums by reusing one 4-bit full_adder ripple slice over NIBBLES consecutive cycles, least-significant nibble first. The carry between nibbles is held in a register. Provides a start/busy/done handshake to the surrounding control logic and holds the result until the next accepted start. The slice is built from four full_adder cells whose cin is fed from the carry register, not tied to 0.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand (operand width = 4*NIBBLES); legal range 2..16.

Ports:
clk  input  1  single clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only in IDLE.
a  input  4*NIBBLES  operand A; captured on accepted start.
b  input  4*NIBBLES  operand B; captured on accepted start.
busy  output  1  high while nibbles are being added.
done  output  1  one-cycle pulse; sum final while high.
sum  output  4*NIBBLES+1  result; MSB = final carry out.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, sum=0, carry reg=0, nibble index=0, operand regs=0.
- States: IDLE, ADD, DONE.
- IDLE: start=1 at edge k -> latch a,b; clear sum to 0; carry=0; idx=0; go to ADD.
- ADD: each cycle, slice adds A_reg[4*idx+:4] + B_reg[4*idx+:4] + carry. On the edge, the 4-bit result is written to sum[4*idx+:4], carry <= slice cout, and idx increments. When idx==NIBBLES-1, also write sum[4*NIBBLES] <= slice cout, then go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- busy=1 exactly in ADD, i.e. cycles k+1..k+NIBBLES. done=1 in cycle k+NIBBLES+1. Total latency from start edge to done: NIBBLES+1 cycles. Minimum start-to-start spacing: NIBBLES+2 cycles.
- start is ignored in ADD and in DONE; it is not queued. start held high continuously yields back-to-back operations, with one accepted each time IDLE is reached.
- Operands are captured on start; changes to a/b during ADD have no effect.
- sum holds its final value through DONE and IDLE until the next accepted start, which clears it.
- Intermediate sum values (partially written nibbles) are visible during ADD and are not valid until done.
- Arithmetic: unsigned, modulo 2^(4*NIBBLES+1); no overflow is possible in sum.
- Reset asserted mid-ADD aborts immediately to the reset values; no done pulse is generated.

Optional Feature:
SERIAL_SUB_EN: when defined, adds input port sub (1 bit, captured with operands on start). If sub=1, B nibbles are inverted into the slice and the initial carry is 1, so sum[4*NIBBLES-1:0] = A-B mod 2^(4*NIBBLES). sum[4*NIBBLES] is the final carry, where 1 means no borrow (A>=B). If sub=0, or when the macro is undefined, the block performs addition only and has no sub port. Timing is identical in both cases.

Test Plan:
- NIBBLES=4, a=0x1234, b=0x4321, start pulse -> busy high 4 cycles, done in cycle 5 after start edge, sum=0x05555.
- a=0xFFFF, b=0x0001 -> carry ripples through all nibbles, sum=0x10000; a=0xFFFF, b=0xFFFF -> sum=0x1FFFE.
- Pulse start again 2 cycles into an operation with different operands -> ignored; first result unchanged; exactly one done pulse.
- Assert rst_n low 2 cycles into ADD -> busy=0, sum=0, no done pulse; a fresh start then a=0x0F0F, b=0x00F1 -> sum=0x01000.
- start held high for 20 cycles with a=0x0001, b=0x0001 -> done pulses spaced every 6 cycles, sum=0x00002 at each pulse.
- SERIAL_SUB_EN defined, sub=1, a=0x0005, b=0x0007 -> sum=0x0FFFE (MSB 0 = borrow); a=0x0007, b=0x0005 -> sum=0x10002.
